// File: rtl/pes_vehicle_detect.sv
//------------------------------------------------------------------------------
// pes_vehicle_detect : loop-detector conditioning and vehicle queue for the farm road.
// Build option: PES_SENSOR_HOLD_EN keeps sensor asserted while the loop is still occupied.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pes_vehicle_detect #(
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int SERVICE_CYCLES  = 16,
  parameter int CNT_W           = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             loop_raw,
  input  logic [2:0]       light_farm,
  output logic             sensor,
  output logic [CNT_W-1:0] vehicle_count,
  output logic             overflow
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int SW = (SERVICE_CYCLES > 1) ? $clog2(SERVICE_CYCLES) : 1;

  localparam logic [DW-1:0]    C_DCNT_MAX   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0]    C_STIMER_MAX = SW'(SERVICE_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_CNT_MAX    = '1;
  localparam logic [2:0]       C_GREEN      = 3'b001;

  logic             r_sync1;
  logic             r_sync2;
  logic             r_db;
  logic [DW-1:0]    r_dcnt;
  logic [SW-1:0]    r_stimer;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;
  logic             r_sensor;

  logic             w_db_flip;
  logic             w_db_next;
  logic             w_arrival;
  logic             w_svc_active;
  logic             w_service;
  logic [DW-1:0]    w_dcnt_next;
  logic [SW-1:0]    w_stimer_next;
  logic [CNT_W-1:0] w_count_next;
  logic             w_overflow_next;
  logic             w_sensor_next;

  // Debounce: a level change is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_comb begin
    w_db_flip   = 1'b0;
    w_dcnt_next = '0;
    if (r_sync2 != r_db) begin
      if (r_dcnt == C_DCNT_MAX) begin
        w_db_flip = 1'b1;
      end else begin
        w_dcnt_next = r_dcnt + 1'b1;
      end
    end
  end

  assign w_db_next = w_db_flip ? ~r_db : r_db;
  assign w_arrival = w_db_flip & ~r_db;

  // Service timer runs only while farm is green with vehicles queued.
  assign w_svc_active = (light_farm == C_GREEN) && (r_count != '0);
  assign w_service    = w_svc_active && (r_stimer == C_STIMER_MAX);

  always_comb begin
    w_stimer_next = '0;
    if (w_svc_active && !w_service) begin
      w_stimer_next = r_stimer + 1'b1;
    end
  end

  // Coincident arrival and service cancel; saturated arrivals are dropped and flagged.
  always_comb begin
    w_count_next    = r_count;
    w_overflow_next = r_overflow;
    if (w_arrival && !w_service) begin
      if (r_count == C_CNT_MAX) begin
        w_overflow_next = 1'b1;
      end else begin
        w_count_next = r_count + 1'b1;
      end
    end else if (w_service && !w_arrival) begin
      w_count_next = r_count - 1'b1;
    end
  end

`ifdef PES_SENSOR_HOLD_EN
  assign w_sensor_next = (w_count_next != '0) | w_db_next;
`else
  assign w_sensor_next = (w_count_next != '0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_db       <= 1'b0;
      r_dcnt     <= '0;
      r_stimer   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_sensor   <= 1'b0;
    end else begin
      r_sync1    <= loop_raw;
      r_sync2    <= r_sync1;
      r_db       <= w_db_next;
      r_dcnt     <= w_dcnt_next;
      r_stimer   <= w_stimer_next;
      r_count    <= w_count_next;
      r_overflow <= w_overflow_next;
      r_sensor   <= w_sensor_next;
    end
  end

  assign sensor        = r_sensor;
  assign vehicle_count = r_count;
  assign overflow      = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_pes_vehicle_detect.sv
//------------------------------------------------------------------------------
// tb_pes_vehicle_detect : directed bench for the vehicle detector, default and 2-bit counter instances.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_pes_vehicle_detect;

  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b001;

`ifdef PES_SENSOR_HOLD_EN
  localparam logic HOLD_EXP = 1'b1;
`else
  localparam logic HOLD_EXP = 1'b0;
`endif

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b1;
  logic       loop_a  = 1'b0;
  logic       loop_b  = 1'b0;
  logic [2:0] light_a = RED;
  logic [2:0] light_b = RED;

  logic       sensor_a;
  logic [3:0] cnt_a;
  logic       ovf_a;
  logic       sensor_b;
  logic [1:0] cnt_b;
  logic       ovf_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pes_vehicle_detect #(.DEBOUNCE_CYCLES(8), .SERVICE_CYCLES(16), .CNT_W(4)) u_dut_a (
    .clk           (clk),
    .rst_n         (rst_n),
    .loop_raw      (loop_a),
    .light_farm    (light_a),
    .sensor        (sensor_a),
    .vehicle_count (cnt_a),
    .overflow      (ovf_a)
  );

  pes_vehicle_detect #(.DEBOUNCE_CYCLES(8), .SERVICE_CYCLES(16), .CNT_W(2)) u_dut_b (
    .clk           (clk),
    .rst_n         (rst_n),
    .loop_raw      (loop_b),
    .light_farm    (light_b),
    .sensor        (sensor_b),
    .vehicle_count (cnt_b),
    .overflow      (ovf_b)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic veh_a();
    loop_a = 1'b1;
    tick(40);
    loop_a = 1'b0;
    tick(40);
  endtask

  task automatic veh_b();
    loop_b = 1'b1;
    tick(40);
    loop_b = 1'b0;
    tick(40);
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    for (int i = 0; i < 20; i++) begin
      loop_a = ~loop_a;
      loop_b = ~loop_b;
      tick(1);
      n_cmp++;
      if ({sensor_a, cnt_a, ovf_a, sensor_b, cnt_b, ovf_b} !== 10'd0) begin
        n_err++;
        $display("FAIL reset_hold cycle %0d: got a=%b/%0d/%b b=%b/%0d/%b want all 0",
                 i, sensor_a, cnt_a, ovf_a, sensor_b, cnt_b, ovf_b);
      end
    end
    loop_a = 1'b0;
    loop_b = 1'b0;
    rst_n  = 1'b1;
    tick(12);
    n_cmp++;
    if ({sensor_a, cnt_a, ovf_a, sensor_b, cnt_b, ovf_b} !== 10'd0) begin
      n_err++;
      $display("FAIL reset_release: got a=%b/%0d/%b b=%b/%0d/%b want all 0",
               sensor_a, cnt_a, ovf_a, sensor_b, cnt_b, ovf_b);
    end
  endtask

  task automatic test_glitch();
    loop_a = 1'b1;
    tick(7);
    loop_a = 1'b0;
    tick(20);
    n_cmp++;
    if (cnt_a !== 4'd0 || sensor_a !== 1'b0) begin
      n_err++;
      $display("FAIL glitch_reject: got count=%0d sensor=%b want 0/0", cnt_a, sensor_a);
    end
    loop_a = 1'b1;
    tick(9);
    n_cmp++;
    if (cnt_a !== 4'd0) begin
      n_err++;
      $display("FAIL arrival_early: got count=%0d at edge 8 want 0", cnt_a);
    end
    tick(1);
    n_cmp++;
    if (cnt_a !== 4'd1 || sensor_a !== 1'b1) begin
      n_err++;
      $display("FAIL arrival_edge9: got count=%0d sensor=%b want 1/1", cnt_a, sensor_a);
    end
    tick(30);
    loop_a = 1'b0;
    tick(40);
    n_cmp++;
    if (cnt_a !== 4'd1) begin
      n_err++;
      $display("FAIL release_no_effect: got count=%0d want 1", cnt_a);
    end
  endtask

  task automatic test_service();
    veh_a();
    veh_a();
    n_cmp++;
    if (cnt_a !== 4'd3) begin
      n_err++;
      $display("FAIL three_queued: got count=%0d want 3", cnt_a);
    end
    light_a = GREEN;
    tick(15);
    n_cmp++;
    if (cnt_a !== 4'd3) begin
      n_err++;
      $display("FAIL service_early: got count=%0d at green-edge 14 want 3", cnt_a);
    end
    tick(1);
    n_cmp++;
    if (cnt_a !== 4'd2) begin
      n_err++;
      $display("FAIL service_1: got count=%0d at green-edge 15 want 2", cnt_a);
    end
    tick(16);
    n_cmp++;
    if (cnt_a !== 4'd1 || sensor_a !== 1'b1) begin
      n_err++;
      $display("FAIL service_2: got count=%0d sensor=%b want 1/1", cnt_a, sensor_a);
    end
    tick(16);
    n_cmp++;
    if (cnt_a !== 4'd0 || sensor_a !== 1'b0) begin
      n_err++;
      $display("FAIL service_3: got count=%0d sensor=%b want 0/0", cnt_a, sensor_a);
    end
    light_a = RED;
    veh_a();
    light_a = GREEN;
    tick(10);
    light_a = YELLOW;
    tick(1);
    light_a = GREEN;
    tick(15);
    n_cmp++;
    if (cnt_a !== 4'd1) begin
      n_err++;
      $display("FAIL yellow_restart_early: got count=%0d want 1", cnt_a);
    end
    tick(1);
    n_cmp++;
    if (cnt_a !== 4'd0) begin
      n_err++;
      $display("FAIL yellow_restart: got count=%0d want 0", cnt_a);
    end
    light_a = RED;
  endtask

  task automatic test_simultaneous();
    veh_a();
    veh_a();
    light_a = GREEN;
    tick(6);
    loop_a = 1'b1;
    tick(9);
    n_cmp++;
    if (cnt_a !== 4'd2) begin
      n_err++;
      $display("FAIL simul_before: got count=%0d want 2", cnt_a);
    end
    tick(1);
    n_cmp++;
    if (cnt_a !== 4'd2) begin
      n_err++;
      $display("FAIL simul_cancel: got count=%0d want 2", cnt_a);
    end
    tick(15);
    n_cmp++;
    if (cnt_a !== 4'd2) begin
      n_err++;
      $display("FAIL simul_restart_early: got count=%0d want 2", cnt_a);
    end
    tick(1);
    n_cmp++;
    if (cnt_a !== 4'd1) begin
      n_err++;
      $display("FAIL simul_restart: got count=%0d want 1", cnt_a);
    end
    tick(16);
    light_a = RED;
    loop_a  = 1'b0;
    tick(20);
    n_cmp++;
    if (cnt_a !== 4'd0 || sensor_a !== 1'b0) begin
      n_err++;
      $display("FAIL simul_drain: got count=%0d sensor=%b want 0/0", cnt_a, sensor_a);
    end
  endtask

  task automatic test_hold();
    loop_a = 1'b1;
    tick(10);
    n_cmp++;
    if (cnt_a !== 4'd1) begin
      n_err++;
      $display("FAIL hold_arrival: got count=%0d want 1", cnt_a);
    end
    light_a = GREEN;
    tick(16);
    n_cmp++;
    if (cnt_a !== 4'd0 || sensor_a !== HOLD_EXP) begin
      n_err++;
      $display("FAIL hold_served: got count=%0d sensor=%b want 0/%b", cnt_a, sensor_a, HOLD_EXP);
    end
    light_a = RED;
    loop_a  = 1'b0;
    tick(9);
    n_cmp++;
    if (sensor_a !== HOLD_EXP) begin
      n_err++;
      $display("FAIL hold_release_early: got sensor=%b want %b", sensor_a, HOLD_EXP);
    end
    tick(1);
    n_cmp++;
    if (sensor_a !== 1'b0 || cnt_a !== 4'd0) begin
      n_err++;
      $display("FAIL hold_release: got sensor=%b count=%0d want 0/0", sensor_a, cnt_a);
    end
  endtask

  task automatic test_saturation();
    veh_b();
    veh_b();
    veh_b();
    n_cmp++;
    if (cnt_b !== 2'd3 || ovf_b !== 1'b0) begin
      n_err++;
      $display("FAIL sat_full: got count=%0d ovf=%b want 3/0", cnt_b, ovf_b);
    end
    veh_b();
    n_cmp++;
    if (cnt_b !== 2'd3 || ovf_b !== 1'b1) begin
      n_err++;
      $display("FAIL sat_drop: got count=%0d ovf=%b want 3/1", cnt_b, ovf_b);
    end
    veh_b();
    light_b = GREEN;
    tick(48);
    n_cmp++;
    if (cnt_b !== 2'd0 || ovf_b !== 1'b1 || sensor_b !== 1'b0) begin
      n_err++;
      $display("FAIL sat_drain: got count=%0d ovf=%b sensor=%b want 0/1/0", cnt_b, ovf_b, sensor_b);
    end
    light_b = RED;
    loop_b  = 1'b1;
    tick(5);
    rst_n = 1'b0;
    #2;
    n_cmp++;
    if (ovf_b !== 1'b0 || cnt_b !== 2'd0) begin
      n_err++;
      $display("FAIL sat_async_reset: got ovf=%b count=%0d want 0/0", ovf_b, cnt_b);
    end
    loop_b = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(12);
    n_cmp++;
    if (cnt_b !== 2'd0 || ovf_b !== 1'b0 || sensor_b !== 1'b0) begin
      n_err++;
      $display("FAIL sat_after_reset: got count=%0d ovf=%b sensor=%b want 0/0/0", cnt_b, ovf_b, sensor_b);
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_service();
    test_simultaneous();
    test_hold();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
